// File: rtl/alu_inv_pkg.sv
// Shared types and constants for the square-mod / CA preimage search.
package alu_inv_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam int   B_W    = 4;
  localparam logic OP_SQM = 1'b0;
  localparam logic OP_CA  = 1'b1;

endpackage

// File: rtl/sqm_ca_eval.sv
// Combinational forward ALU model: op0 (cand*cand)%m on the low B_W bits, op1 one CA step under rule.
// Zero latency, no handshake; m==0 yields 0 rather than an undefined remainder.
module sqm_ca_eval
  import alu_inv_pkg::*;
#(
  parameter int A_W = 8
) (
  input  logic           op,
  input  logic [A_W-1:0] cand,
  input  logic [A_W-1:0] m,
  input  logic [B_W-1:0] rule,
  output logic [A_W-1:0] y
);

  localparam int W = (A_W > 2 * B_W) ? A_W : 2 * B_W;

  logic [2*B_W-1:0] w_sq;
  logic [W-1:0]     w_sq_ext;
  logic [W-1:0]     w_m_ext;
  logic [W-1:0]     w_rem;
  logic [A_W-1:0]   w_y_ca;

  assign w_sq     = {{B_W{1'b0}}, cand[B_W-1:0]} * {{B_W{1'b0}}, cand[B_W-1:0]};
  assign w_sq_ext = W'(w_sq);
  assign w_m_ext  = W'(m);
  assign w_rem    = (m == '0) ? '0 : (w_sq_ext % w_m_ext);

  // Each output bit looks at itself and its upper neighbour; the top bit wraps to bit 0.
  always_comb begin
    w_y_ca = '0;
    for (int i = 0; i < A_W; i++) begin
      w_y_ca[i] = rule[{cand[(i + 1) % A_W], cand[i]}];
    end
  end

  assign y = (op == OP_CA) ? w_y_ca : w_rem[A_W-1:0];

endmodule

// File: rtl/alu_preimage_search.sv
// Linear search for the smallest preimage, one candidate per cycle; done pulses at k+2 on a hit, N+2 on a miss.
// start is only honoured in IDLE; pulses while searching or in DONE are dropped.
module alu_preimage_search
  import alu_inv_pkg::*;
#(
  parameter int A_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  input  logic [A_W-1:0] y_in,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic           err,
  output logic [A_W-1:0] result
);

  state_t         r_state;
  logic           r_op;
  logic [A_W-1:0] r_m;
  logic [B_W-1:0] r_rule;
  logic [A_W-1:0] r_t;
  logic [A_W-1:0] r_k;
  logic           r_miss;

  logic [A_W-1:0] w_y;
  logic           w_match;
  logic           w_last;

  sqm_ca_eval #(.A_W(A_W)) u_eval (
    .op   (r_op),
    .cand (r_k),
    .m    (r_m),
    .rule (r_rule),
    .y    (w_y)
  );

  assign w_match = (w_y == r_t);
  assign w_last  = (r_op == OP_CA) ? (r_k == '1) : (r_k == A_W'(2 ** B_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= 1'b0;
      r_m     <= '0;
      r_rule  <= '0;
      r_t     <= '0;
      r_k     <= '0;
      r_miss  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op   <= op;
            r_m    <= a_in;
            r_rule <= b_in;
            r_t    <= y_in;
            r_k    <= '0;
            r_miss <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            if (op == OP_SQM && a_in == '0) begin
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (w_match) begin
            found   <= 1'b1;
            result  <= r_k;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else if (w_last) begin
            // A miss reports one cycle later than a hit on the last candidate would.
            r_miss  <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_k <= r_k + A_W'(1);
          end
        end
        DONE: begin
          done    <= r_miss;
          r_miss  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
